// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, issues word-aligned requests to
// instruction memory, buffers in-order responses in a small FIFO and hands
// {instruction, pc} to decode. A redirect flushes the buffer and marks every
// in-flight response as stale so it is discarded on arrival.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instruction,
  output logic [31:0] instr_pc
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    IDLE,
    FETCH
  } state_t;

  state_t           state_q;
  state_t           state_d;

  logic [31:0]      pc_q;
  logic [31:0]      resp_pc_q;
  logic [31:0]      redirect_target;
  logic [CNT_W-1:0] outstanding_q;
  logic [CNT_W-1:0] outstanding_next;
  logic [CNT_W-1:0] drop_cnt_q;
  logic [CNT_W-1:0] fifo_count_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W-1:0] wr_ptr_q;
  logic [CNT_W:0]   credit_used;

  logic [31:0]      fifo_instr [FIFO_DEPTH];
  logic [31:0]      fifo_pc    [FIFO_DEPTH];

  logic             req_fire;
  logic             resp_dec;
  logic             resp_drop;
  logic             push;
  logic             pop;
  logic             fifo_empty;

  // The two low bits of a redirect target are forced to zero, so they are
  // intentionally not consumed by any logic.
  logic             unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  assign redirect_target = {redirect_pc[31:2], 2'b00};

  // State register for the IDLE -> FETCH sequencer.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and request issue: a request is only offered when a FIFO slot
  // is guaranteed for its response (buffered plus in-flight, stale included).
  always_comb begin
    state_d        = state_q;
    imem_req_valid = 1'b0;
    credit_used    = {1'b0, fifo_count_q} + {1'b0, outstanding_q};
    case (state_q)
      IDLE: begin
        state_d = FETCH;
      end
      FETCH: begin
        imem_req_valid = !redirect_valid &&
                         (credit_used < (CNT_W+1)'(FIFO_DEPTH));
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign imem_req_addr = pc_q;
  assign req_fire      = imem_req_valid && imem_req_ready;

  // Response classification: a response arriving with a redirect is already
  // stale, as is any response while earlier redirects still owe drops.
  always_comb begin
    resp_dec         = imem_resp_valid && (outstanding_q != '0);
    resp_drop        = imem_resp_valid && ((drop_cnt_q != '0) || redirect_valid);
    push             = imem_resp_valid && (drop_cnt_q == '0) && !redirect_valid;
    fifo_empty       = (fifo_count_q == '0);
    instr_valid      = !fifo_empty && !redirect_valid;
    pop              = instr_valid && instr_ready;
    outstanding_next = outstanding_q + CNT_W'(req_fire) - CNT_W'(resp_dec);
  end

  // Decode sees the FIFO head directly; an empty buffer presents zeros.
  always_comb begin
    instruction = '0;
    instr_pc    = '0;
    if (!fifo_empty) begin
      instruction = fifo_instr[rd_ptr_q];
      instr_pc    = fifo_pc[rd_ptr_q];
    end
  end

  // Control state: PC, response PC, credit counters and FIFO pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q          <= RESET_PC;
      resp_pc_q     <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      fifo_count_q  <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      outstanding_q <= outstanding_next;
      if (redirect_valid) begin
        pc_q         <= redirect_target;
        resp_pc_q    <= redirect_target;
        drop_cnt_q   <= outstanding_next;
        fifo_count_q <= '0;
        rd_ptr_q     <= '0;
        wr_ptr_q     <= '0;
      end else begin
        if (req_fire) begin
          pc_q <= pc_q + 32'd4;
        end
        if (resp_drop) begin
          drop_cnt_q <= drop_cnt_q - CNT_W'(1);
        end
        if (push) begin
          wr_ptr_q  <= wr_ptr_q + PTR_W'(1);
          resp_pc_q <= resp_pc_q + 32'd4;
        end
        if (pop) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
        fifo_count_q <= fifo_count_q + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // FIFO storage: written on every kept response, never reset.
  always_ff @(posedge clk) begin
    if (push && rst_n) begin
      fifo_instr[wr_ptr_q] <= imem_resp_data;
      fifo_pc[wr_ptr_q]    <= resp_pc_q;
    end
  end

  // A response with nothing outstanding means memory broke the protocol.
  assert property (@(posedge clk) disable iff (!rst_n)
                   imem_resp_valid |-> (outstanding_q != '0));

endmodule
